// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared size encodings, FSM states, byte-enable constants and lane helpers
//   Used by mem_access_unit and mem_access_unit_load_align.
package mem_access_unit_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERROR  = 2'd3
  } mau_state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Byte lane actually used: low address bits below the access size are forced to zero.
  function automatic logic [1:0] lane_of(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_HALF: lane_of = {addr_lo[1], 1'b0};
      SIZE_WORD: lane_of = 2'b00;
      default:   lane_of = addr_lo;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: byte_enables = BE_BYTE0 << lane;
      SIZE_HALF: byte_enables = lane[1] ? BE_HALF_HI : BE_HALF_LO;
      SIZE_WORD: byte_enables = BE_WORD;
      default:   byte_enables = BE_NONE;
    endcase
  endfunction

  function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: replicate_store = {4{data[7:0]}};
      SIZE_HALF: replicate_store = {2{data[15:0]}};
      default:   replicate_store = data;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    misaligned = ((size == SIZE_HALF) && addr_lo[0]) || ((size == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// rtl/mem_access_unit_load_align.sv - combinational load lane select and sign/zero extension
//   rdata       : raw word from data memory
//   lane        : byte lane of the access (already forced to the size alignment)
//   size        : access size encoding
//   is_unsigned : 1 = zero-extend, 0 = sign-extend (ignored for words)
//   value       : right-aligned, extended load result
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (size)
      SIZE_BYTE: value = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SIZE_HALF: value = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default:   value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit between execute stage and a handshaked data memory
//   Optional build macro MEM_ALIGN_CHECK_EN: misaligned halfword/word accesses go to ERROR
//   instead of being issued with the low address bits forced.
//   Pipeline side : MEM_START, MEM_WRITE, MEM_SIZE, MEM_UNSIGNED, ALU_RESULT, STORE_DATA in;
//                   data_memory_in_v, LOAD_VALID, STALL, MEM_ERR out.
//   Memory side   : DM_REQ, DM_WE, DM_ADDR, DM_BE, DM_WDATA out; DM_ACK, DM_RDATA in.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        MEM_START,
  input  logic        MEM_WRITE,
  input  logic [1:0]  MEM_SIZE,
  input  logic        MEM_UNSIGNED,
  input  logic [31:0] ALU_RESULT,
  input  logic [31:0] STORE_DATA,
  output logic        DM_REQ,
  output logic        DM_WE,
  output logic [31:0] DM_ADDR,
  output logic [3:0]  DM_BE,
  output logic [31:0] DM_WDATA,
  input  logic        DM_ACK,
  input  logic [31:0] DM_RDATA,
  output logic [31:0] data_memory_in_v,
  output logic        LOAD_VALID,
  output logic        STALL,
  output logic        MEM_ERR
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  mau_state_e    state;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    ld_lane;
  logic [1:0]    ld_size;
  logic          ld_unsigned;
  logic [1:0]    start_lane;
  logic          start_bad;
  logic [31:0]   aligned_data;

  assign start_lane = lane_of(MEM_SIZE, ALU_RESULT[1:0]);

`ifdef MEM_ALIGN_CHECK_EN
  assign start_bad = (MEM_SIZE == SIZE_ILLEGAL) || misaligned(MEM_SIZE, ALU_RESULT[1:0]);
`else
  assign start_bad = (MEM_SIZE == SIZE_ILLEGAL);
`endif

  // Stall rises in the same cycle the request is presented so the pipeline cannot advance past it.
  assign STALL = ((state == ST_IDLE) && MEM_START) || (state == ST_ACCESS) || (state == ST_ERROR);

  mem_access_unit_load_align u_load_align (
    .rdata       (DM_RDATA),
    .lane        (ld_lane),
    .size        (ld_size),
    .is_unsigned (ld_unsigned),
    .value       (aligned_data)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state            <= ST_IDLE;
      wait_cnt         <= '0;
      DM_REQ           <= 1'b0;
      DM_WE            <= 1'b0;
      DM_ADDR          <= 32'h0;
      DM_BE            <= BE_NONE;
      DM_WDATA         <= 32'h0;
      data_memory_in_v <= 32'h0;
      LOAD_VALID       <= 1'b0;
      MEM_ERR          <= 1'b0;
      ld_lane          <= 2'b00;
      ld_size          <= SIZE_BYTE;
      ld_unsigned      <= 1'b0;
    end else begin
      LOAD_VALID <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (MEM_START) begin
            wait_cnt <= '0;
            if (start_bad) begin
              MEM_ERR <= 1'b1;
              state   <= ST_ERROR;
            end else begin
              MEM_ERR     <= 1'b0;
              DM_REQ      <= 1'b1;
              DM_WE       <= MEM_WRITE;
              DM_ADDR     <= {ALU_RESULT[31:2], 2'b00};
              DM_BE       <= byte_enables(MEM_SIZE, start_lane);
              DM_WDATA    <= replicate_store(MEM_SIZE, STORE_DATA);
              ld_lane     <= start_lane;
              ld_size     <= MEM_SIZE;
              ld_unsigned <= MEM_UNSIGNED;
              state       <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // An acknowledge in the last allowed cycle still completes the access.
          if (DM_ACK) begin
            DM_REQ <= 1'b0;
            state  <= ST_DONE;
            if (!DM_WE) begin
              LOAD_VALID       <= 1'b1;
              data_memory_in_v <= aligned_data;
            end
          end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            DM_REQ  <= 1'b0;
            MEM_ERR <= 1'b1;
            state   <= ST_ERROR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_ERROR: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        MEM_START, MEM_WRITE, MEM_UNSIGNED, DM_ACK;
  logic [1:0]  MEM_SIZE;
  logic [31:0] ALU_RESULT, STORE_DATA, DM_RDATA;

  logic        dm_req, dm_we, load_valid, stall, mem_err;
  logic [31:0] dm_addr, dm_wdata, ld_val;
  logic [3:0]  dm_be;

  logic        to_req, to_we, to_lv, to_stall, to_err;
  logic [31:0] to_addr, to_wdata, to_val;
  logic [3:0]  to_be;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] last_load = 32'h0;

  always #5 CLK = ~CLK;

  mem_access_unit dut (
    .CLK(CLK), .RESET_N(RESET_N), .MEM_START(MEM_START), .MEM_WRITE(MEM_WRITE),
    .MEM_SIZE(MEM_SIZE), .MEM_UNSIGNED(MEM_UNSIGNED), .ALU_RESULT(ALU_RESULT),
    .STORE_DATA(STORE_DATA), .DM_REQ(dm_req), .DM_WE(dm_we), .DM_ADDR(dm_addr),
    .DM_BE(dm_be), .DM_WDATA(dm_wdata), .DM_ACK(DM_ACK), .DM_RDATA(DM_RDATA),
    .data_memory_in_v(ld_val), .LOAD_VALID(load_valid), .STALL(stall), .MEM_ERR(mem_err)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .CLK(CLK), .RESET_N(RESET_N), .MEM_START(MEM_START), .MEM_WRITE(MEM_WRITE),
    .MEM_SIZE(MEM_SIZE), .MEM_UNSIGNED(MEM_UNSIGNED), .ALU_RESULT(ALU_RESULT),
    .STORE_DATA(STORE_DATA), .DM_REQ(to_req), .DM_WE(to_we), .DM_ADDR(to_addr),
    .DM_BE(to_be), .DM_WDATA(to_wdata), .DM_ACK(DM_ACK), .DM_RDATA(DM_RDATA),
    .data_memory_in_v(to_val), .LOAD_VALID(to_lv), .STALL(to_stall), .MEM_ERR(to_err)
  );

  // One access on the main unit, checked every cycle against expectations derived
  // from the access rules. Returns in the DONE cycle; the following cycle is IDLE.
  task automatic run_access(input logic w, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] rdata, input int delay, input bit noise);
    int          lane, nbits;
    logic [31:0] e_addr, e_wdata, e_load, mask;
    logic [3:0]  e_be;
    lane   = (size == 2) ? 0 : (size == 1) ? int'(addr & 32'h2) : int'(addr & 32'h3);
    e_addr = addr & 32'hFFFF_FFFC;
    if (size == 0) begin
      e_be = 4'(1 << lane);  e_wdata = {24'h0, data[7:0]} * 32'h0101_0101;
    end else if (size == 1) begin
      e_be = 4'(3 << lane);  e_wdata = {16'h0, data[15:0]} * 32'h0001_0001;
    end else begin
      e_be = 4'hF;           e_wdata = data;
    end
    if (size == 2) e_load = rdata;
    else begin
      nbits  = 8 * (int'(size) + 1);
      mask   = (32'h1 << nbits) - 1;
      e_load = (rdata >> (8 * lane)) & mask;
      if (!uns && e_load[nbits-1]) e_load = e_load | ~mask;
    end

    @(negedge CLK);
    MEM_START = 1'b1; MEM_WRITE = w; MEM_SIZE = size; MEM_UNSIGNED = uns;
    ALU_RESULT = addr; STORE_DATA = data; DM_ACK = 1'b0; DM_RDATA = $urandom;
    #1;
    n_chk++;
    if ({stall, dm_req, load_valid} !== 3'b100)
      $display("FAIL start_cycle: stall/req/lv got %b want 100", {stall, dm_req, load_valid});
    else n_pass++;

    for (int c = 0; c <= delay; c++) begin
      @(negedge CLK);
      if (noise) begin
        MEM_START = 1'($urandom); MEM_WRITE = 1'($urandom); MEM_SIZE = 2'($urandom);
        MEM_UNSIGNED = 1'($urandom); ALU_RESULT = $urandom; STORE_DATA = $urandom;
      end else MEM_START = 1'b0;
      DM_ACK   = (c == delay);
      DM_RDATA = (c == delay) ? rdata : $urandom;
      n_chk++;
      if ({dm_req, dm_we, dm_addr, dm_be, dm_wdata, stall, load_valid} !==
          {1'b1, w, e_addr, e_be, e_wdata, 1'b1, 1'b0})
        $display("FAIL access_cycle%0d: req=%b we=%b addr=%h be=%b wdata=%h stall=%b lv=%b want req=1 we=%b addr=%h be=%b wdata=%h stall=1 lv=0",
                 c, dm_req, dm_we, dm_addr, dm_be, dm_wdata, stall, load_valid, w, e_addr, e_be, e_wdata);
      else n_pass++;
    end

    @(negedge CLK);
    MEM_START = noise ? 1'($urandom) : 1'b0;
    DM_ACK    = noise ? 1'($urandom) : 1'b0;
    if (!w) last_load = e_load;
    n_chk++;
    if ({dm_req, stall, load_valid, ld_val, mem_err} !== {1'b0, 1'b0, ~w, last_load, 1'b0})
      $display("FAIL done_cycle: req=%b stall=%b lv=%b val=%h err=%b want 0 0 %b %h 0",
               dm_req, stall, load_valid, ld_val, mem_err, ~w, last_load);
    else n_pass++;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; MEM_START = 1'b0; MEM_WRITE = 1'b0; MEM_SIZE = 2'b00; MEM_UNSIGNED = 1'b0;
    ALU_RESULT = 32'h0; STORE_DATA = 32'h0; DM_ACK = 1'b0; DM_RDATA = 32'h0;
    repeat (2) @(negedge CLK);
    n_chk++;
    if ({dm_req, dm_we, dm_addr, dm_be, dm_wdata, ld_val, load_valid, stall, mem_err} !== '0)
      $display("FAIL reset_main: got %h want 0", {dm_req, dm_we, dm_addr, dm_be, dm_wdata, ld_val, load_valid, stall, mem_err});
    else n_pass++;
    n_chk++;
    if ({to_req, to_we, to_addr, to_be, to_wdata, to_val, to_lv, to_stall, to_err} !== '0)
      $display("FAIL reset_short: got %h want 0", {to_req, to_we, to_addr, to_be, to_wdata, to_val, to_lv, to_stall, to_err});
    else n_pass++;
    RESET_N = 1'b1;
    @(negedge CLK);
    n_chk++;
    if ({dm_req, stall, load_valid, mem_err} !== 4'b0000)
      $display("FAIL reset_release: got %b want 0000", {dm_req, stall, load_valid, mem_err});
    else n_pass++;
  endtask

  // Short-timeout unit times out; the main unit keeps waiting and ignores a second start.
  task automatic test_timeout();
    logic [31:0] r;
    @(negedge CLK);
    MEM_START = 1'b1; MEM_WRITE = 1'b0; MEM_SIZE = 2'b10; MEM_UNSIGNED = 1'b0;
    ALU_RESULT = 32'h0000_0400; DM_ACK = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      MEM_START = 1'b0;
      n_chk++;
      if ({to_req, to_stall, to_err} !== 3'b110)
        $display("FAIL timeout_wait%0d: req/stall/err got %b want 110", c, {to_req, to_stall, to_err});
      else n_pass++;
    end
    @(negedge CLK);
    n_chk++;
    if ({to_req, to_err, to_lv} !== 3'b010)
      $display("FAIL timeout_error: req/err/lv got %b want 010", {to_req, to_err, to_lv});
    else n_pass++;
    @(negedge CLK);
    n_chk++;
    if ({to_req, to_err, to_lv, to_stall} !== 4'b0100)
      $display("FAIL timeout_sticky: req/err/lv/stall got %b want 0100", {to_req, to_err, to_lv, to_stall});
    else n_pass++;
    MEM_START = 1'b1; ALU_RESULT = 32'h0000_0808;
    @(negedge CLK);
    MEM_START = 1'b0;
    n_chk++;
    if ({to_err, to_req, to_addr} !== {1'b0, 1'b1, 32'h0000_0808})
      $display("FAIL timeout_clear: err/req/addr got %b %b %h want 0 1 00000808", to_err, to_req, to_addr);
    else n_pass++;
    n_chk++;
    if ({dm_req, dm_addr} !== {1'b1, 32'h0000_0400})
      $display("FAIL start_ignored_in_access: req/addr got %b %h want 1 00000400", dm_req, dm_addr);
    else n_pass++;
    r = $urandom; DM_ACK = 1'b1; DM_RDATA = r;
    @(negedge CLK);
    DM_ACK = 1'b0;
    last_load = r;
    n_chk++;
    if ({to_lv, to_val, load_valid, ld_val} !== {1'b1, r, 1'b1, r})
      $display("FAIL timeout_recover: lv=%b val=%h main_lv=%b main_val=%h want 1 %h 1 %h", to_lv, to_val, load_valid, ld_val, r, r);
    else n_pass++;
  endtask

  task automatic test_lb_sign();
    run_access(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 1'b0);
    n_chk++;
    if (ld_val !== 32'hFFFF_FF80) $display("FAIL lb_sign: got %h want ffffff80", ld_val);
    else n_pass++;
  endtask

  task automatic test_sh_store();
    run_access(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_ABCD, $urandom, 0, 1'b0);
  endtask

  task automatic test_lhu_delay();
    run_access(1'b0, 2'b01, 1'b1, 32'h0000_0200, 32'h0, $urandom | 32'h0000_8000, 5, 1'b0);
    n_chk++;
    if (ld_val[31:16] !== 16'h0) $display("FAIL lhu_zero_ext: upper got %h want 0000", ld_val[31:16]);
    else n_pass++;
  endtask

  task automatic test_illegal_size();
    @(negedge CLK);
    MEM_START = 1'b1; MEM_SIZE = 2'b11; MEM_WRITE = 1'b0; ALU_RESULT = $urandom; DM_ACK = 1'b0;
    @(negedge CLK);
    MEM_START = 1'b0;
    n_chk++;
    if ({dm_req, mem_err, load_valid} !== 3'b010)
      $display("FAIL illegal_error: req/err/lv got %b want 010", {dm_req, mem_err, load_valid});
    else n_pass++;
    @(negedge CLK);
    n_chk++;
    if ({dm_req, mem_err, load_valid, stall} !== 4'b0100)
      $display("FAIL illegal_exit: req/err/lv/stall got %b want 0100", {dm_req, mem_err, load_valid, stall});
    else n_pass++;
    run_access(1'b0, 2'b00, 1'b1, 32'h0000_0041, 32'h0, $urandom, 1, 1'b0);
  endtask

  task automatic test_misaligned();
`ifdef MEM_ALIGN_CHECK_EN
    @(negedge CLK);
    MEM_START = 1'b1; MEM_SIZE = 2'b10; MEM_WRITE = 1'b0; ALU_RESULT = 32'h0000_0102; DM_ACK = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      MEM_START = 1'b0;
      n_chk++;
      if ({dm_req, mem_err, load_valid} !== 3'b010)
        $display("FAIL misaligned_err%0d: req/err/lv got %b want 010", c, {dm_req, mem_err, load_valid});
      else n_pass++;
    end
    run_access(1'b0, 2'b01, 1'b1, 32'h0000_0306, 32'h0, $urandom, 0, 1'b0);
`else
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, $urandom, 1, 1'b0);
    run_access(1'b0, 2'b01, 1'b0, 32'h0000_0203, 32'h0, $urandom, 0, 1'b0);
`endif
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0, $urandom, 0, 1'b0);
    run_access(1'b1, 2'b10, 1'b0, 32'h0000_0014, $urandom, $urandom, 0, 1'b0);
    run_access(1'b1, 2'b00, 1'b0, 32'h0000_0017, $urandom, $urandom, 0, 1'b0);
    run_access(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, $urandom, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < 24; i++) begin
      sz = 2'($urandom_range(0, 2));
      a  = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz == 2'b10) a[1:0] = 2'b00;
`endif
      run_access(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, $urandom_range(0, 6), 1'b1);
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge CLK);
    MEM_START = 1'b1; MEM_WRITE = 1'b0; MEM_SIZE = 2'b10; ALU_RESULT = 32'h0000_0500; DM_ACK = 1'b0;
    @(negedge CLK);
    MEM_START = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    n_chk++;
    if ({dm_req, dm_we, dm_addr, dm_be, dm_wdata, ld_val, load_valid, stall, mem_err} !== '0)
      $display("FAIL reset_mid_access: got %h want 0", {dm_req, dm_we, dm_addr, dm_be, dm_wdata, ld_val, load_valid, stall, mem_err});
    else n_pass++;
    @(negedge CLK);
    RESET_N = 1'b1; DM_ACK = 1'b1; DM_RDATA = $urandom;
    last_load = 32'h0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      DM_ACK = 1'b0;
      n_chk++;
      if ({dm_req, load_valid, stall, ld_val, mem_err} !== '0)
        $display("FAIL stray_ack%0d: req=%b lv=%b stall=%b val=%h err=%b want all 0", c, dm_req, load_valid, stall, ld_val, mem_err);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_lb_sign();
    test_sh_store();
    test_lhu_delay();
    test_illegal_size();
    test_misaligned();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles waiting for DM_ACK before error.
REQ-002 CLK  input  1  single system clock, rising edge.
REQ-003 RESET_N  input  1  reset, asynchronous assert, active-low.
REQ-004 MEM_START  input  1  execute stage requests an access; sampled in IDLE only.
REQ-005 MEM_WRITE  input  1  1 = store, 0 = load.
REQ-006 MEM_SIZE  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 MEM_UNSIGNED  input  1  load zero-extends when 1, sign-extends when 0.
REQ-008 ALU_RESULT  input  32  effective byte address.
REQ-009 STORE_DATA  input  32  store value, right-aligned.
REQ-010 DM_REQ  output  1  data-memory request, held until DM_ACK.
REQ-011 DM_WE  output  1  write enable to data memory.
REQ-012 DM_ADDR  output  32  word address, ALU_RESULT with bits [1:0] = 0.
REQ-013 DM_BE  output  4  byte enables.
REQ-014 DM_WDATA  output  32  store data replicated into selected lanes.
REQ-015 DM_ACK  input  1  memory completes access this cycle.
REQ-016 DM_RDATA  input  32  read word, valid with DM_ACK.
REQ-017 data_memory_in_v  output  32  aligned, extended load value for the writeback mux.
REQ-018 LOAD_VALID  output  1  one-cycle pulse, data_memory_in_v newly valid.
REQ-019 STALL  output  1  holds the pipeline while an access is outstanding.
REQ-020 MEM_ERR  output  1  sticky error flag, cleared by next accepted MEM_START.

Function
REQ-021 FSM states SHALL be IDLE, ACCESS, DONE, ERROR.
REQ-022 IDLE + MEM_START: latch address/size/data/controls, enter ACCESS, assert DM_REQ next cycle; STALL asserts combinationally same cycle.
REQ-023 ACCESS: DM_REQ, DM_WE, DM_ADDR, DM_BE, DM_WDATA SHALL be stable until DM_ACK; DM_ACK -> DONE.
REQ-024 DONE: one cycle; STALL deasserts; load drives LOAD_VALID = 1; return to IDLE.
REQ-025 Minimum latency MEM_START to LOAD_VALID SHALL be 3 cycles with DM_ACK returned on first DM_REQ cycle.
REQ-026 Byte lanes: byte BE = 1<<addr[1:0]; halfword BE = 0011 or 1100 by addr[1]; word BE = 1111.
REQ-027 Load extraction SHALL select lane by addr[1:0] and extend per MEM_UNSIGNED to 32 bits; word ignores MEM_UNSIGNED.
REQ-028 data_memory_in_v SHALL hold last load value until next load completes; stores do not change it.
REQ-029 Wait counter SHALL count ACCESS cycles; at TIMEOUT_CYCLES without DM_ACK -> ERROR, drop DM_REQ, set MEM_ERR.
REQ-030 MEM_SIZE = 11 at MEM_START SHALL go to ERROR with no DM_REQ.
REQ-031 ERROR: one cycle, STALL deasserted on exit, no LOAD_VALID, return to IDLE.
REQ-032 MEM_START outside IDLE SHALL be ignored; DM_ACK outside ACCESS SHALL be ignored.

Reset
REQ-033 RESET_N low: state IDLE, DM_REQ 0, DM_WE 0, DM_ADDR 0, DM_BE 0, DM_WDATA 0, data_memory_in_v 0, LOAD_VALID 0, STALL 0, MEM_ERR 0, counter 0.
REQ-034 Reset mid-ACCESS SHALL abandon the access immediately; a later stray DM_ACK has no effect.

Configuration
REQ-035 MEM_ALIGN_CHECK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 -> ERROR, no DM_REQ; undefined: misaligned address issued with bits forced (halfword addr[0], word addr[1:0] ignored).

Structure
REQ-036 Shared package SHALL hold size encodings, FSM state enum, byte-enable constants.
REQ-037 One sub-module load_align (lane select + extension), purely combinational.

Verification
REQ-038 LB addr 0x103, DM_RDATA 0x80FF_0000, ack first cycle -> data_memory_in_v 0xFFFF_FF80, LOAD_VALID on cycle 3.
REQ-039 SH addr 0x102, STORE_DATA 0x1234_ABCD -> DM_BE 1100, DM_WDATA 0xABCD_ABCD, DM_ADDR 0x100, no LOAD_VALID.
REQ-040 LHU addr 0x200, DM_ACK delayed 5 cycles -> DM_REQ held 6 cycles, STALL high throughout, result 0x0000_xxxx zero-extended.
REQ-041 No DM_ACK, TIMEOUT_CYCLES=4 -> MEM_ERR set after 4 ACCESS cycles, DM_REQ 0, next MEM_START clears MEM_ERR.
REQ-042 RESET_N low during ACCESS then ack -> all outputs reset values, no LOAD_VALID.
REQ-043 With MEM_ALIGN_CHECK_EN, LW addr 0x102 -> MEM_ERR 1, DM_REQ never asserted.
